// File: rtl/vga_capture_if.sv
// VGA input stream and framebuffer write port of vga_capture.
// The capture block takes the slave view; the VGA source / write sink takes master.
interface vga_capture_if;
    logic        iVGA_H_SYNC;
    logic        iVGA_V_SYNC;
    logic [9:0]  iVGA_R;
    logic [9:0]  iVGA_G;
    logic [9:0]  iVGA_B;
    logic        oWrite;
    logic [19:0] oAddress;
    logic [9:0]  oCoord_X;
    logic [9:0]  oCoord_Y;
    logic [9:0]  oR;
    logic [9:0]  oG;
    logic [9:0]  oB;

    modport master (
        output iVGA_H_SYNC, iVGA_V_SYNC, iVGA_R, iVGA_G, iVGA_B,
        input  oWrite, oAddress, oCoord_X, oCoord_Y, oR, oG, oB
    );

    modport slave (
        input  iVGA_H_SYNC, iVGA_V_SYNC, iVGA_R, iVGA_G, iVGA_B,
        output oWrite, oAddress, oCoord_X, oCoord_Y, oR, oG, oB
    );
endinterface

// File: rtl/vga_capture.sv
// VGA capture: rebuilds pixel coordinates from sync edges, verifies line/frame timing,
// and emits framebuffer writes. Define VGA_CAPTURE_CHECKSUM_EN to build the frame checksum.
module vga_capture #(
    parameter int X_START = 144,
    parameter int Y_START = 35,
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    vga_capture_if.slave bus,
    input  logic         iEnable,
    output logic         oLocked,
    output logic         oFrame_Done,
    output logic         oErr,
    output logic [31:0]  oFrame_Sum
);
    localparam logic [10:0] X_LO    = 11'(X_START);
    localparam logic [10:0] X_HI    = 11'(X_START + H_ACT);
    localparam logic [9:0]  Y_LO    = 10'(Y_START);
    localparam logic [9:0]  Y_HI    = 10'(Y_START + V_ACT);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [19:0] H_ACT_W = 20'(H_ACT);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    logic        s_hs, s_vs, s_hs_d, s_vs_d, s_en;
    logic [9:0]  s_r, s_g, s_b;
    logic [10:0] r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        r_v_pend;
    state_t      r_state;
    logic        r_cap_en, r_err, r_done, r_write;
    logic [19:0] r_addr;
    logic [9:0]  r_x, r_y, r_r, r_g, r_b;

    logic        w_h_fall, w_v_fall, w_h_bad, w_v_bad, w_mis;
    logic        w_act, w_wr, w_done;
    logic [9:0]  w_x, w_y;
    logic [19:0] w_addr;

    // Input stage: sync, enable and colour registered once
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s_hs   <= 1'b0;
            s_vs   <= 1'b0;
            s_hs_d <= 1'b0;
            s_vs_d <= 1'b0;
            s_en   <= 1'b0;
        end else begin
            s_hs   <= bus.iVGA_H_SYNC;
            s_vs   <= bus.iVGA_V_SYNC;
            s_hs_d <= s_hs;
            s_vs_d <= s_vs;
            s_en   <= iEnable;
        end
    end

    always_ff @(posedge iCLK) begin
        s_r <= bus.iVGA_R;
        s_g <= bus.iVGA_G;
        s_b <= bus.iVGA_B;
    end

    assign w_h_fall = s_hs_d & ~s_hs;
    assign w_v_fall = s_vs_d & ~s_vs;

    // A saturated counter means the sync stopped arriving, so it is treated as a mismatch
    assign w_h_bad = (w_h_fall & (r_h_cnt != H_LAST)) | (r_h_cnt == 11'h7FF);
    assign w_v_bad = (w_v_fall & (r_v_cnt != V_LAST)) | (r_v_cnt == 10'h3FF);
    assign w_mis   = w_h_bad | w_v_bad;

    assign w_act  = r_cap_en && (r_state == LOCKED) &&
                    (r_h_cnt >= X_LO) && (r_h_cnt < X_HI) &&
                    (r_v_cnt >= Y_LO) && (r_v_cnt < Y_HI);
    assign w_wr   = w_act & ~w_mis;
    assign w_x    = 10'(r_h_cnt - X_LO);
    assign w_y    = r_v_cnt - Y_LO;
    assign w_addr = 20'(w_y) * H_ACT_W + 20'(w_x);
    assign w_done = w_v_fall & ~w_mis & r_cap_en & (r_state == LOCKED);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            r_v_pend <= 1'b0;
        end else begin
            if (w_h_fall)
                r_h_cnt <= '0;
            else if (r_h_cnt != 11'h7FF)
                r_h_cnt <= r_h_cnt + 11'd1;

            // A vsync fall anywhere in the previous line restarts the line count
            if (w_h_fall) begin
                r_v_pend <= 1'b0;
                if (r_v_pend | w_v_fall)
                    r_v_cnt <= '0;
                else if (r_v_cnt != 10'h3FF)
                    r_v_cnt <= r_v_cnt + 10'd1;
            end else if (w_v_fall) begin
                r_v_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state  <= SEARCH;
            r_cap_en <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_done;
            case (r_state)
                SEARCH: begin
                    if (w_v_fall)
                        r_state <= MEASURE;
                end
                MEASURE: begin
                    if (w_mis) begin
                        r_state <= SEARCH;
                    end else if (w_v_fall) begin
                        r_state  <= LOCKED;
                        r_cap_en <= s_en;
                    end
                end
                LOCKED: begin
                    if (w_mis) begin
                        r_state  <= SEARCH;
                        r_cap_en <= 1'b0;
                        r_err    <= 1'b1;
                    end else if (w_v_fall) begin
                        r_cap_en <= s_en;
                    end
                end
                default: r_state <= SEARCH;
            endcase
        end
    end

    // Output stage: address, coordinates and colour hold between writes
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
        end else begin
            r_write <= w_wr;
            if (w_wr) begin
                r_addr <= w_addr;
                r_x    <= w_x;
                r_y    <= w_y;
                r_r    <= s_r;
                r_g    <= s_g;
                r_b    <= s_b;
            end
        end
    end

`ifdef VGA_CAPTURE_CHECKSUM_EN
    logic [31:0] r_acc, r_sum, w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_write ? (32'(r_r) + 32'(r_g) + 32'(r_b)) : 32'd0);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_acc <= '0;
            r_sum <= '0;
        end else begin
            r_acc <= w_v_fall ? 32'd0 : w_acc_nxt;
            if (w_done)
                r_sum <= w_acc_nxt;
        end
    end

    assign oFrame_Sum = r_sum;
`else
    assign oFrame_Sum = 32'd0;
`endif

    assign bus.oWrite   = r_write;
    assign bus.oAddress = r_addr;
    assign bus.oCoord_X = r_x;
    assign bus.oCoord_Y = r_y;
    assign bus.oR       = r_r;
    assign bus.oG       = r_g;
    assign bus.oB       = r_b;
    assign oLocked      = (r_state == LOCKED);
    assign oFrame_Done  = r_done;
    assign oErr         = r_err;
endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a reduced 20x10 raster (12x5 active).
// The driver pushes expected writes, frame-done pulses and status samples; a monitor compares them.
module tb_vga_capture;
    localparam int XS = 4, YS = 2, HA = 12, VA = 5, HT = 20, VT = 10;
    localparam int HS_W = 2, VS_W = 2;
`ifdef VGA_CAPTURE_CHECKSUM_EN
    localparam int SUM_ON = 1;
`else
    localparam int SUM_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        locked, done, err;
    logic [31:0] fsum;
    int          cyc = 0;

    vga_capture_if bus();

    vga_capture #(
        .X_START(XS), .Y_START(YS), .H_ACT(HA), .V_ACT(VA), .H_TOTAL(HT), .V_TOTAL(VT)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .bus(bus), .iEnable(en),
        .oLocked(locked), .oFrame_Done(done), .oErr(err), .oFrame_Sum(fsum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic [19:0] addr; logic [9:0] x; logic [9:0] y; logic [9:0] c; } wr_t;
    typedef struct { int due; logic [31:0] sum; } dn_t;
    typedef struct { int due; bit zero_all; bit lck; bit er; } st_t;

    wr_t wq[$];
    dn_t dq[$];
    st_t sq[$];
    wr_t mw;
    dn_t md;
    st_t ms;
    int  n_chk = 0;
    int  n_pass = 0;
    int  prev_sum = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_st(input int due, input bit zero_all, input bit lck, input bit er);
        st_t s;
        s.due = due; s.zero_all = zero_all; s.lck = lck; s.er = er;
        sq.push_back(s);
    endtask

    // One raster frame; pin cycle c of line L maps to DUT pixel x=c-1-XS, y=L-YS
    task automatic send_frame(input bit cap, input bit done_exp, input int short_line,
                              input int drop_line, input int en_line, input int rst_line,
                              input bit chk, input bit pre_lck, input bit lck, input bit er);
        int  len, x, y, fs;
        bit  cap_now;
        wr_t w;
        dn_t d;
        fs = 0;
        cap_now = cap;
        for (int L = 0; L < VT; L++) begin
            len = (L == short_line) ? HT - 1 : HT;
            for (int c = 0; c < len; c++) begin
                tick();
                x = c - 1 - XS;
                y = L - YS;
                bus.iVGA_H_SYNC = (c >= HS_W);
                bus.iVGA_V_SYNC = (L >= VS_W);
                bus.iVGA_R = 10'(x + y);
                bus.iVGA_G = 10'(x + y);
                bus.iVGA_B = 10'(x + y);
                if (L == 0 && c == 0) begin
                    if (done_exp) begin
                        d.due = cyc + 2;
                        d.sum = 32'(prev_sum * SUM_ON);
                        dq.push_back(d);
                    end
                    if (chk) begin
                        push_st(cyc + 1, 1'b0, pre_lck, er);
                        push_st(cyc + 2, 1'b0, lck, er);
                    end
                end
                if (c == 0 && L == short_line + 1 && short_line >= 0) begin
                    push_st(cyc + 1, 1'b0, 1'b1, 1'b0);
                    push_st(cyc + 2, 1'b0, 1'b0, 1'b1);
                end
                if (c == 0 && L == drop_line) en = 1'b0;
                if (c == 0 && L == en_line) en = 1'b1;
                if (c == 0 && L == rst_line) begin
                    rst_n = 1'b0;
                    wq.delete();
                    dq.delete();
                    cap_now = 1'b0;
                    push_st(cyc, 1'b1, 1'b0, 1'b0);
                end
                if (c == 2 && L == rst_line) rst_n = 1'b1;
                if (cap_now && x >= 0 && x < HA && y >= 0 && y < VA) begin
                    w.due = cyc + 2;
                    w.addr = 20'(y * HA + x);
                    w.x = 10'(x);
                    w.y = 10'(y);
                    w.c = 10'(x + y);
                    wq.push_back(w);
                    fs += 3 * (x + y);
                end
            end
            if (L == short_line) cap_now = 1'b0;
        end
        prev_sum = fs;
    endtask

    always @(negedge clk) begin
        if (wq.size() > 0 && wq[0].due == cyc) begin
            mw = wq.pop_front();
            check("write_strobe", bus.oWrite === 1'b1, longint'(bus.oWrite), 1);
            check("write_addr", bus.oAddress === mw.addr, longint'(bus.oAddress), longint'(mw.addr));
            check("coord_x", bus.oCoord_X === mw.x, longint'(bus.oCoord_X), longint'(mw.x));
            check("coord_y", bus.oCoord_Y === mw.y, longint'(bus.oCoord_Y), longint'(mw.y));
            check("pixel_rgb", bus.oR === mw.c && bus.oG === mw.c && bus.oB === mw.c,
                  longint'(bus.oR), longint'(mw.c));
        end else begin
            check("idle_write", bus.oWrite === 1'b0, longint'(bus.oWrite), 0);
        end

        if (dq.size() > 0 && dq[0].due == cyc) begin
            md = dq.pop_front();
            check("frame_done", done === 1'b1, longint'(done), 1);
            check("frame_sum", fsum === md.sum, longint'(fsum), longint'(md.sum));
        end else begin
            check("idle_frame_done", done === 1'b0, longint'(done), 0);
        end

        while (sq.size() > 0 && sq[0].due <= cyc) begin
            ms = sq.pop_front();
            if (ms.zero_all) begin
                check("reset_outputs",
                      {bus.oWrite, bus.oAddress, bus.oCoord_X, bus.oCoord_Y, bus.oR, bus.oG,
                       bus.oB, done, locked, err, fsum} == '0,
                      longint'({bus.oWrite, done, locked, err, bus.oAddress}), 0);
            end else begin
                check("locked", locked === ms.lck, longint'(locked), longint'(ms.lck));
                check("err", err === ms.er, longint'(err), longint'(ms.er));
            end
        end
    end

    initial begin
        bus.iVGA_H_SYNC = 1'b1;
        bus.iVGA_V_SYNC = 1'b1;
        bus.iVGA_R = '0;
        bus.iVGA_G = '0;
        bus.iVGA_B = '0;
        en = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        push_st(cyc, 1'b1, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        push_st(cyc, 1'b0, 1'b0, 1'b0);

        //         cap  done short drop en  rst  chk pre lck err
        send_frame(1'b0, 1'b0, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0); // F0 -> MEASURE
        send_frame(1'b1, 1'b0, -1, -1, -1, -1, 1'b1, 1'b0, 1'b1, 1'b0); // F1 locks, captured
        send_frame(1'b1, 1'b1, -1, -1, -1, -1, 1'b1, 1'b1, 1'b1, 1'b0); // F2
        send_frame(1'b1, 1'b1,  3, -1, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0); // F3 short line
        send_frame(1'b0, 1'b0, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0, 1'b1); // F4 measure
        send_frame(1'b1, 1'b0, -1, -1, -1, -1, 1'b1, 1'b0, 1'b1, 1'b1); // F5 relocked
        send_frame(1'b1, 1'b1, -1,  4, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0); // F6 enable dropped
        send_frame(1'b0, 1'b1, -1, -1,  5, -1, 1'b1, 1'b1, 1'b1, 1'b1); // F7 not captured
        send_frame(1'b1, 1'b0, -1, -1, -1,  4, 1'b0, 1'b0, 1'b0, 1'b0); // F8 reset mid-frame
        send_frame(1'b0, 1'b0, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0); // F9 measure
        send_frame(1'b1, 1'b0, -1, -1, -1, -1, 1'b1, 1'b0, 1'b1, 1'b0); // F10 relocked
        send_frame(1'b1, 1'b1, -1, -1, -1, -1, 1'b1, 1'b1, 1'b1, 1'b0); // F11
        repeat (6) tick();

        check("pending_writes", wq.size() == 0, wq.size(), 0);
        check("pending_done", dq.size() == 0, dq.size(), 0);
        check("pending_status", sq.size() == 0, sq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
